// File: rtl/arp_reply_tx.sv
// ARP reply transmitter: serialises a 60-byte Ethernet II ARP reply
// onto a byte-wide valid/ready stream, with a 1-deep pending slot.
`ifndef FPGA_IP
`define FPGA_IP 32'hC0A8_0132
`endif

module arp_reply_tx #(
   parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01,
   parameter logic [31:0] MY_IP     = `FPGA_IP,
   parameter int          FRAME_LEN = 60
) (
   input  logic        clk50,
   input  logic        rst_n,
   input  logic        send_arp_reply,
   input  logic [47:0] req_dst_mac,
   input  logic [31:0] req_dst_ip,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic        busy,
   output logic [7:0]  drop_cnt
);

   localparam int IW = $clog2(FRAME_LEN);
   localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] HDR_LEN = IW'(42);

   typedef enum logic {IDLE, SEND} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [47:0]   mac_q, mac_d;
   logic [31:0]   ip_q, ip_d;
   logic          pend_q, pend_d;
   logic [47:0]   pmac_q, pmac_d;
   logic [31:0]   pip_q, pip_d;
   logic [7:0]    drop_q, drop_d;

   logic          beat;
   logic          at_last;
   logic          drop_inc;
   logic [335:0]  hdr;

   assign tx_valid = (state_q == SEND);
   assign at_last  = (idx_q == LAST);
   assign beat     = tx_valid & tx_ready;
   assign tx_last  = tx_valid & at_last;
   assign busy     = tx_valid | pend_q;
   assign drop_cnt = drop_q;

   // 42 header bytes, byte 0 in the top octet
   assign hdr = {mac_q, MY_MAC, 16'h0806, 16'h0001, 16'h0800,
                 8'h06, 8'h04, 16'h0002, MY_MAC, MY_IP,
                 mac_q, ip_q};

   // Byte mux: header bytes, zero pad beyond, zero when idle
   always_comb begin
      tx_data = 8'h00;
      if (tx_valid && idx_q < HDR_LEN)
         tx_data = hdr[9'((41 - int'(idx_q)) * 8) +: 8];
   end

   // State register and latched request fields
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mac_q   <= '0;
         ip_q    <= '0;
         pend_q  <= 1'b0;
         pmac_q  <= '0;
         pip_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mac_q   <= mac_d;
         ip_q    <= ip_d;
         pend_q  <= pend_d;
         pmac_q  <= pmac_d;
         pip_q   <= pip_d;
         drop_q  <= drop_d;
      end
   end

   // Next state: request capture, beat advance, pending hand-off
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      mac_d    = mac_q;
      ip_d     = ip_q;
      pend_d   = pend_q;
      pmac_d   = pmac_q;
      pip_d    = pip_q;
      drop_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (send_arp_reply) begin
               mac_d   = req_dst_mac;
               ip_d    = req_dst_ip;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (beat && at_last) begin
               idx_d = '0;
               if (pend_q) begin
                  mac_d    = pmac_q;
                  ip_d     = pip_q;
                  pend_d   = 1'b0;
                  drop_inc = send_arp_reply;
               end else if (send_arp_reply) begin
                  mac_d = req_dst_mac;
                  ip_d  = req_dst_ip;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (beat)
                  idx_d = idx_q + 1'b1;
               if (send_arp_reply) begin
                  if (!pend_q) begin
                     pend_d = 1'b1;
                     pmac_d = req_dst_mac;
                     pip_d  = req_dst_ip;
                  end else begin
                     drop_inc = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      drop_d = drop_q;
      if (drop_inc && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;
   end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Testbench for arp_reply_tx: frame-level reference model plus
// directed corner sequences and randomized traffic.
module tb_arp_reply_tx;

   localparam logic [47:0] MYMAC = 48'h02_00_00_00_00_01;
   localparam logic [31:0] MYIP  = 32'hC0A8_0132;
   localparam int          FL    = 60;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        send;
   logic [47:0] rmac;
   logic [31:0] rip;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready;
   logic        busy;
   logic [7:0]  drop_cnt;

   arp_reply_tx dut (
      .clk50          (clk),
      .rst_n          (rst_n),
      .send_arp_reply (send),
      .req_dst_mac    (rmac),
      .req_dst_ip     (rip),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_last        (tx_last),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] mac;
      logic [31:0] ip;
   } req_t;

   typedef struct {
      int         idx;
      logic [7:0] exp;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   req_t       q[$];
   int         idx_m = 0;
   int         drop_m = 0;
   int         frames = 0;
   logic [7:0] cap[FL];
   vec_t       tbl[16];

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Expected frame byte from field layout
   function automatic logic [7:0] exp_byte(input logic [47:0] m,
                                           input logic [31:0] ip,
                                           input int i);
      if (i < 6)  return m[8*(5-i) +: 8];
      if (i < 12) return MYMAC[8*(11-i) +: 8];
      case (i)
         12: return 8'h08;
         13: return 8'h06;
         14: return 8'h00;
         15: return 8'h01;
         16: return 8'h08;
         17: return 8'h00;
         18: return 8'h06;
         19: return 8'h04;
         20: return 8'h00;
         21: return 8'h02;
         default: ;
      endcase
      if (i < 28) return MYMAC[8*(27-i) +: 8];
      if (i < 32) return MYIP[8*(31-i) +: 8];
      if (i < 38) return m[8*(37-i) +: 8];
      if (i < 42) return ip[8*(41-i) +: 8];
      return 8'h00;
   endfunction

   // Reference model: queue of outstanding frames (current + pending)
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         idx_m  = 0;
         drop_m = 0;
         chk("rst_valid", {63'd0, tx_valid}, 64'd0);
         chk("rst_busy", {63'd0, busy}, 64'd0);
         chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
      end else begin
         chk("valid", {63'd0, tx_valid}, {63'd0, q.size() > 0});
         chk("busy", {63'd0, busy}, {63'd0, q.size() > 0});
         chk("drop", {56'd0, drop_cnt}, 64'(drop_m));
         if (q.size() > 0 && tx_valid) begin
            chk("data", {56'd0, tx_data},
                {56'd0, exp_byte(q[0].mac, q[0].ip, idx_m)});
            chk("last", {63'd0, tx_last}, {63'd0, idx_m == FL-1});
         end
         if (send) begin
            if (q.size() < 2) q.push_back('{mac: rmac, ip: rip});
            else if (drop_m < 255) drop_m++;
         end
         if (tx_valid && tx_ready && q.size() > 0) begin
            cap[idx_m] = tx_data;
            if (idx_m == FL-1) begin
               void'(q.pop_front());
               idx_m = 0;
               frames++;
            end else begin
               idx_m++;
            end
         end
      end
   end

   task automatic pulse(input logic [47:0] m, input logic [31:0] ip);
      send = 1'b1;
      rmac = m;
      rip  = ip;
      @(posedge clk);
      #1 send = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || q.size() > 0) && n < budget) begin
         @(posedge clk);
         #1 n++;
      end
      chk("idle_timeout", {63'd0, n < budget}, 64'd1);
   endtask

   task automatic wait_idx(input int target);
      int n = 0;
      while (idx_m < target && n < 1000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("idx_timeout", {63'd0, n < 1000}, 64'd1);
   endtask

   task automatic check_table(input string tag);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s_b%0d", tag, tbl[i].idx),
             {56'd0, cap[tbl[i].idx]}, {56'd0, tbl[i].exp});
   endtask

   initial begin
      int n;
      int f0;
      tbl = '{'{0, 8'h11}, '{5, 8'h66}, '{6, 8'h02}, '{11, 8'h01},
              '{12, 8'h08}, '{13, 8'h06}, '{20, 8'h00}, '{21, 8'h02},
              '{28, 8'hC0}, '{31, 8'h32}, '{38, 8'hC0}, '{41, 8'h64},
              '{42, 8'h00}, '{50, 8'h00}, '{59, 8'h00}, '{37, 8'h66}};
      rst_n = 1'b0;
      send = 1'b0;
      rmac = '0;
      rip = '0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_valid", {63'd0, tx_valid}, 64'd0);
      chk("reset_data", {56'd0, tx_data}, 64'd0);
      chk("reset_last", {63'd0, tx_last}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_drop", {56'd0, drop_cnt}, 64'd0);

      // Test 1: back-to-back beats
      tx_ready = 1'b1;
      pulse(48'h11_22_33_44_55_66, 32'hC0A8_0164);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("t1_busy_cycles", 64'(n), 64'd60);
      check_table("t1");

      // Test 2: stalls with ready 1,0,0 pattern
      @(posedge clk);
      #1 pulse(48'h11_22_33_44_55_66, 32'hC0A8_0164);
      n = 0;
      while ((busy || q.size() > 0) && n < 1000) begin
         tx_ready = (n % 3 == 0);
         @(posedge clk);
         #1 n++;
      end
      chk("t2_timeout", {63'd0, n < 1000}, 64'd1);
      check_table("t2");
      tx_ready = 1'b1;

      // Test 3: pending taken, third dropped
      f0 = frames;
      pulse(48'h11_22_33_44_55_66, 32'hC0A8_0164);
      wait_idx(10);
      pulse(48'hAA_AA_AA_AA_AA_AA, 32'h0A00_0001);
      wait_idx(20);
      pulse(48'hCC_CC_CC_CC_CC_CC, 32'h0A00_0002);
      wait_idle(400);
      chk("t3_drop", {56'd0, drop_cnt}, 64'd1);
      chk("t3_frames", 64'(frames - f0), 64'd2);

      // Test 4: pulse coincident with last beat
      pulse(48'h12_34_56_78_9A_BC, 32'hC0A8_0110);
      n = 0;
      while (!tx_last && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk("t4_timeout", {63'd0, n < 200}, 64'd1);
      pulse(48'hBB_01_02_03_04_05, 32'hC0A8_0111);
      chk("t4_valid", {63'd0, tx_valid}, 64'd1);
      chk("t4_byte0", {56'd0, tx_data}, 64'hBB);
      chk("t4_last", {63'd0, tx_last}, 64'd0);
      chk("t4_drop", {56'd0, drop_cnt}, 64'd1);
      wait_idle(400);

      // Test 5: reset mid-frame
      pulse(48'h11_22_33_44_55_66, 32'hC0A8_0164);
      wait_idx(30);
      rst_n = 1'b0;
      #1;
      chk("t5_valid", {63'd0, tx_valid}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_drop", {56'd0, drop_cnt}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      pulse(48'h5A_5B_5C_5D_5E_5F, 32'h0102_0304);
      chk("t5_new_b0", {56'd0, tx_data}, 64'h5A);
      wait_idle(400);
      chk("t5_cap0", {56'd0, cap[0]}, 64'h5A);
      chk("t5_cap41", {56'd0, cap[41]}, 64'h04);

      // Test 6: drop saturation during stalled frame
      tx_ready = 1'b0;
      f0 = frames;
      for (int i = 0; i < 301; i++) begin
         send = 1'b1;
         rmac = {16'hD0D0, 32'(i)};
         rip = 32'(i);
         @(posedge clk);
         #1;
      end
      send = 1'b0;
      @(posedge clk);
      #1 chk("t6_drop_sat", {56'd0, drop_cnt}, 64'd255);
      tx_ready = 1'b1;
      wait_idle(400);
      chk("t6_frames", 64'(frames - f0), 64'd2);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tx_ready = ($urandom_range(0, 9) < 7);
         send = ($urandom_range(0, 24) == 0);
         rmac = {$urandom(), 16'($urandom())};
         rip = $urandom();
         @(posedge clk);
         #1;
      end
      send = 1'b0;
      tx_ready = 1'b1;
      wait_idle(400);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
